// File: rtl/cover_seq_pkg.sv
// rtl/cover_seq_pkg.sv - shared types and constants for the cover hit sequencer
// Holds the sequencer FSM state encoding and the drop counter width and
// saturation value used by cover_hit_sequencer.
package cover_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_e;

  localparam int              DROP_W   = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

endpackage

// File: rtl/cover_rr_pick.sv
// rtl/cover_rr_pick.sv - wrapping find-first-set starting at a pointer
// Purely combinational round-robin picker.
// Ports:
//   req_i   - request bitmap, N bits
//   ptr_i   - search start position (0..N-1)
//   found_o - at least one request bit is set
//   idx_o   - lowest set position at or above ptr_i, wrapping to 0
module cover_rr_pick #(
  parameter int N  = 36,
  parameter int PW = 6
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          found_o,
  output logic [PW-1:0] idx_o
);

  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic [N-1:0]  rot;
  logic [PW-1:0] off;
  logic [PW:0]   sum;

  always_comb begin
    // Rotate so that position ptr_i lands on bit 0; rot[i] = req[(ptr+i) mod N].
    rot     = N'({req_i, req_i} >> ptr_i);
    found_o = 1'b0;
    off     = '0;
    // Descending scan: the last hit written is the lowest offset.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found_o = 1'b1;
        off     = PW'(i);
      end
    end
    sum   = {1'b0, ptr_i} + {1'b0, off};
    idx_o = (sum >= N_W) ? PW'(sum - N_W) : PW'(sum);
  end

endmodule

// File: rtl/cover_hit_sequencer.sv
// rtl/cover_hit_sequencer.sv - serialises coverage hits into a stream of cover indices
// Collects per-point hits into a pending bitmap and reports them one at a time
// in round-robin order over a valid/ready handshake, with a flush that drains
// everything pending and pulses flush_done.
// Optional macro COVER_DEDUP_EN: each point is reported at most once per reset.
// Ports:
//   gbl_clk    - clock, rising edge
//   reset      - synchronous, active-low
//   hit_valid  - per-point hits, flat bit f = group*GRP_W + bit
//   enable     - accept new hits when high
//   flush_req  - single-cycle request to drain all pending hits
//   out_valid  - report available
//   out_ready  - consumer accepts report
//   out_index  - COVER_BASE + f of the reported point
//   flush_done - single-cycle pulse when a flush completes
//   drop_cnt   - saturating count of cycles where hits merged into pending bits
module cover_hit_sequencer
  import cover_seq_pkg::*;
#(
  parameter int              NUM_GRP    = 4,
  parameter int              GRP_W      = 9,
  parameter longint unsigned COVER_BASE = 0,
  parameter int              IDX_W      = 64
) (
  input  logic                     gbl_clk,
  input  logic                     reset,
  input  logic [NUM_GRP*GRP_W-1:0] hit_valid,
  input  logic                     enable,
  input  logic                     flush_req,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_index,
  output logic                     flush_done,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int              N    = NUM_GRP * GRP_W;
  localparam int              PW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0]   LAST = PW'(N - 1);

  seq_state_e        state_q;
  logic [N-1:0]      pending_q, pending_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     cur_q;
  logic              out_valid_q;
  logic [IDX_W-1:0]  out_index_q;
  logic              flush_done_q;
  logic [DROP_W-1:0] drop_q;

  logic [N-1:0]      clr, fresh, cand;
  logic              handshake, hold, drop_hit;
  logic              pick_found;
  logic [PW-1:0]     pick_idx;

`ifdef COVER_DEDUP_EN
  logic [N-1:0]      seen_q;
`endif

  always_comb begin
    handshake = out_valid_q & out_ready;
    hold      = out_valid_q & ~out_ready;
    clr       = '0;
    if (handshake) clr[cur_q] = 1'b1;
    fresh     = hit_valid & {N{enable && (state_q != ST_FLUSH)}};
`ifdef COVER_DEDUP_EN
    fresh     = fresh & ~seen_q;
`endif
    // A re-hit on the point being retired wins: it is not masked by clr and not a drop.
    drop_hit  = |(fresh & pending_q & ~clr);
    pending_d = (pending_q & ~clr) | fresh;
    // Next report comes only from bits already pending before this edge.
    cand      = pending_q & ~clr;
    ptr_d     = ptr_q;
    if (handshake) ptr_d = (cur_q == LAST) ? '0 : cur_q + 1'b1;
  end

  cover_rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req_i   (cand),
    .ptr_i   (ptr_d),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge gbl_clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      ptr_q        <= '0;
      cur_q        <= '0;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      flush_done_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      pending_q    <= pending_d;
      ptr_q        <= ptr_d;
      flush_done_q <= 1'b0;
      if (drop_hit && (drop_q != DROP_MAX)) drop_q <= drop_q + 1'b1;
      if (!hold) begin
        out_valid_q <= pick_found;
        cur_q       <= pick_idx;
        out_index_q <= IDX_W'(COVER_BASE) + IDX_W'(pick_idx);
      end
      case (state_q)
        ST_IDLE: begin
          if (flush_req)       state_q <= ST_FLUSH;
          else if (|pending_d) state_q <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (flush_req)          state_q <= ST_FLUSH;
          else if (!(|pending_d)) state_q <= ST_IDLE;
        end
        ST_FLUSH: begin
          if (!(|pending_d)) begin
            flush_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef COVER_DEDUP_EN
  always_ff @(posedge gbl_clk) begin
    if (!reset) seen_q <= '0;
    else        seen_q <= seen_q | fresh;
  end
`endif

  assign out_valid  = out_valid_q;
  assign out_index  = out_index_q;
  assign flush_done = flush_done_q;
  assign drop_cnt   = drop_q;

endmodule
